vend_slot_arbiter: RTL and testbench

- Shares one vending core between N_SLOTS coin slots.
- Grants the core to one slot at a time (round-robin), forwards that slot's coins to the core and tracks inserted credit.
- Routes the dispense/change result back to the winning slot.
- Aborts stalled transactions: clears the core and reports a refund.
- Sits between the slot front-ends and the vending core's in/out/change interface.

---
 rtl/vend_pkg.sv | 24 ++
 rtl/vend_rr_pick.sv | 34 +++
 rtl/vend_slot_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_vend_slot_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the coin-slot arbiter: coin codes, FSM states and coin value helper.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_VEND,
        ST_CLEAR
    } state_t;

    // Credit value of a coin code in 5-unit steps; the illegal code is worth nothing.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  coin_units = 2'd1;
            COIN_10: coin_units = 2'd2;
            default: coin_units = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin finder: first requester at or after i_ptr, wrapping at N.
module vend_rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr + k reduced modulo N without a divider
            w_j = (IDX_W+1)'(i_ptr) + (IDX_W+1)'(k);
            if (w_j >= (IDX_W+1)'(N)) begin
                w_j = w_j - (IDX_W+1)'(N);
            end
            if (!o_any && i_req[w_j[IDX_W-1:0]]) begin
                o_any                 = 1'b1;
                o_idx                 = w_j[IDX_W-1:0];
                o_gnt[w_j[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_slot_arbiter.sv
// Round-robin arbiter sharing one vending core between coin slots, with stall abort and refund.
// Optional VEND_STATS_EN adds saturating vend/abort counters.
module vend_slot_arbiter
    import vend_pkg::*;
#(
    parameter int unsigned N_SLOTS     = 4,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CREDIT_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SLOTS-1:0]     slot_req,
    input  logic [2*N_SLOTS-1:0]   slot_coin,
    output logic [N_SLOTS-1:0]     slot_gnt,
    output logic [N_SLOTS-1:0]     slot_vend,
    output logic [1:0]             slot_change,
    output logic [N_SLOTS-1:0]     slot_refund,
    output logic [CREDIT_W-1:0]    refund_units,
    output logic [1:0]             vm_in,
    output logic                   vm_rst,
    input  logic [1:0]             vm_out,
    input  logic [1:0]             vm_change,
    output logic                   busy
`ifdef VEND_STATS_EN
    ,
    output logic [15:0]            vend_count,
    output logic [15:0]            abort_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(N_SLOTS);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned SUM_W  = CREDIT_W + 1;

    state_t                r_state;
    logic [N_SLOTS-1:0]    r_gnt;
    logic [N_SLOTS-1:0]    r_vend;
    logic [N_SLOTS-1:0]    r_refund;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_ptr;
    logic [CREDIT_W-1:0]   r_credit;
    logic [CREDIT_W-1:0]   r_refund_units;
    logic [IDLE_W-1:0]     r_idle;
    logic [1:0]            r_change;
    logic [1:0]            r_vm_in;
    logic                  r_vm_rst;
    logic                  r_busy;

    logic [N_SLOTS-1:0]    w_pick_gnt;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic [1:0]            w_coin;
    logic [1:0]            w_units;
    logic [SUM_W-1:0]      w_sum;
    logic                  w_fits;
    logic                  w_has_credit;
    logic                  w_timeout;
    logic                  w_req_g;
    logic [IDX_W-1:0]      w_next_ptr;

    vend_rr_pick #(
        .N     (N_SLOTS),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req (slot_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Granted slot's coin and whether it fits in the credit counter
    assign w_coin       = slot_coin[{r_idx, 1'b0} +: 2];
    assign w_units      = coin_units(w_coin);
    assign w_sum        = SUM_W'(r_credit) + SUM_W'(w_units);
    assign w_fits       = (w_units != 2'd0) && !w_sum[CREDIT_W];
    assign w_has_credit = (r_credit != '0);
    assign w_timeout    = w_has_credit && (r_idle == IDLE_W'(TIMEOUT_CYC - 1));
    assign w_req_g      = slot_req[r_idx];
    assign w_next_ptr   = (r_idx == IDX_W'(N_SLOTS - 1)) ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_gnt          <= '0;
            r_vend         <= '0;
            r_refund       <= '0;
            r_idx          <= '0;
            r_ptr          <= '0;
            r_credit       <= '0;
            r_refund_units <= '0;
            r_idle         <= '0;
            r_change       <= '0;
            r_vm_in        <= COIN_NONE;
            r_vm_rst       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_vend         <= '0;
            r_refund       <= '0;
            r_refund_units <= '0;
            r_change       <= '0;
            r_vm_in        <= COIN_NONE;
            r_vm_rst       <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_gnt    <= w_pick_gnt;
                        r_idx    <= w_pick_idx;
                        r_credit <= '0;
                        r_idle   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    // Core completion beats both timeout and request drop
                    if (vm_out != 2'b00) begin
                        r_vend   <= r_gnt;
                        r_change <= vm_change;
                        r_credit <= '0;
                        r_state  <= ST_VEND;
                    end else if (w_has_credit && (w_timeout || !w_req_g)) begin
                        r_refund       <= r_gnt;
                        r_refund_units <= r_credit;
                        r_vm_rst       <= 1'b0;
                        r_credit       <= '0;
                        r_state        <= ST_CLEAR;
                    end else if (!w_req_g) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_fits) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        r_vm_in  <= w_coin;
                        r_idle   <= '0;
                    end else if (w_has_credit) begin
                        r_idle <= r_idle + IDLE_W'(1);
                    end
                end
                ST_VEND, ST_CLEAR: begin
                    r_gnt   <= '0;
                    r_ptr   <= w_next_ptr;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign slot_gnt     = r_gnt;
    assign slot_vend    = r_vend;
    assign slot_change  = r_change;
    assign slot_refund  = r_refund;
    assign refund_units = r_refund_units;
    assign vm_in        = r_vm_in;
    assign vm_rst       = r_vm_rst;
    assign busy         = r_busy;

`ifdef VEND_STATS_EN
    logic [15:0] r_vend_count;
    logic [15:0] r_abort_count;

    // VEND and CLEAR each last exactly one cycle, so counting state cycles counts events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vend_count  <= '0;
            r_abort_count <= '0;
        end else begin
            if (r_state == ST_VEND && r_vend_count != 16'hFFFF) begin
                r_vend_count <= r_vend_count + 16'd1;
            end
            if (r_state == ST_CLEAR && r_abort_count != 16'hFFFF) begin
                r_abort_count <= r_abort_count + 16'd1;
            end
        end
    end

    assign vend_count  = r_vend_count;
    assign abort_count = r_abort_count;
`endif

endmodule

// File: tb/tb_vend_slot_arbiter.sv
// Scoreboard bench for vend_slot_arbiter: transaction-level model queues expected outputs with cycle stamps.
module tb_vend_slot_arbiter;

    localparam int N        = 4;
    localparam int T        = 16;
    localparam int CW       = 4;
    localparam int CB       = 2 * N;
    localparam int CMAX     = (1 << CW) - 1;
    localparam int K_VEND   = 0;
    localparam int K_REFUND = 1;
    localparam int END_VEND = 0;
    localparam int END_DROP = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    slot_req;
    logic [CB-1:0]   slot_coin;
    logic [N-1:0]    slot_gnt;
    logic [N-1:0]    slot_vend;
    logic [1:0]      slot_change;
    logic [N-1:0]    slot_refund;
    logic [CW-1:0]   refund_units;
    logic [1:0]      vm_in;
    logic            vm_rst;
    logic [1:0]      vm_out;
    logic [1:0]      vm_change;
    logic            busy;

    always #5 clk = ~clk;

    vend_slot_arbiter #(.N_SLOTS(N), .TIMEOUT_CYC(T), .CREDIT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .slot_req     (slot_req),
        .slot_coin    (slot_coin),
        .slot_gnt     (slot_gnt),
        .slot_vend    (slot_vend),
        .slot_change  (slot_change),
        .slot_refund  (slot_refund),
        .refund_units (refund_units),
        .vm_in        (vm_in),
        .vm_rst       (vm_rst),
        .vm_out       (vm_out),
        .vm_change    (vm_change),
        .busy         (busy)
    );

    typedef struct { int val; int stamp; } item_t;
    typedef struct { int kind; int slot; int data; int stamp; } evt_t;

    item_t        coin_q[$];
    item_t        gnt_q[$];
    evt_t         evt_q[$];
    int           cq[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           mon_en = 1'b0;
    int           ptr = 0;
    logic [N-1:0] req_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic void add(input int code, input int n);
        for (int k = 0; k < n; k++) cq.push_back(code);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random coins on every lane, optionally forcing the lane of slot w
    task automatic drive(input int w, input int code);
        slot_coin = CB'($urandom);
        if (w >= 0) slot_coin[2*w +: 2] = 2'(code);
        slot_req = req_mask;
    endtask

    // Monitor: compares each DUT output change against the head of its queue at the stamped cycle
    item_t        m_it;
    evt_t         m_ev;
    logic [N-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (!reset || !mon_en) begin
            prev_gnt = slot_gnt;
        end else begin
            if (coin_q.size() > 0 && coin_q[0].stamp == cyc) begin
                m_it = coin_q.pop_front();
                chk("vm_in", 32'(vm_in), 32'(m_it.val));
            end else if (vm_in != 2'b00) begin
                chk("vm_in_spurious", 32'(vm_in), 32'd0);
            end
            if (gnt_q.size() > 0 && gnt_q[0].stamp == cyc) begin
                m_it = gnt_q.pop_front();
                chk("slot_gnt", 32'(slot_gnt), 32'(m_it.val));
                chk("busy", 32'(busy), 32'(m_it.val != 0));
            end else if (slot_gnt != prev_gnt) begin
                chk("slot_gnt_spurious", 32'(slot_gnt), 32'(prev_gnt));
            end
            prev_gnt = slot_gnt;
            if (evt_q.size() > 0 && evt_q[0].stamp == cyc) begin
                m_ev = evt_q.pop_front();
                if (m_ev.kind == K_VEND) begin
                    chk("slot_vend", 32'(slot_vend), 32'(1 << m_ev.slot));
                    chk("slot_change", 32'(slot_change), 32'(m_ev.data));
                    chk("no_refund_on_vend", 32'(slot_refund), 32'd0);
                end else begin
                    chk("slot_refund", 32'(slot_refund), 32'(1 << m_ev.slot));
                    chk("refund_units", 32'(refund_units), 32'(m_ev.data));
                    chk("vm_rst_clear", 32'(vm_rst), 32'd0);
                end
            end else begin
                if (slot_vend != '0) chk("slot_vend_spurious", 32'(slot_vend), 32'd0);
                if (slot_refund != '0) chk("slot_refund_spurious", 32'(slot_refund), 32'd0);
                if (vm_rst != 1'b1) chk("vm_rst_spurious", 32'(vm_rst), 32'd1);
            end
        end
    end

    // One slot transaction from IDLE; the model works in terms of credit and cycles since the last accepted coin
    task automatic txn(input int s, input int coins[$], input int end_kind, input int out_code, input int chg);
        int w;
        int credit;
        int since;
        int code;
        int u;
        req_mask[s] = 1'b1;
        w = pick(req_mask, ptr);
        credit = 0;
        since = 0;
        drive(-1, 0);
        vm_out = 2'b00;
        vm_change = 2'($urandom);
        gnt_q.push_back('{1 << w, cyc + 1});
        step();
        foreach (coins[i]) begin
            if (credit > 0 && since == T - 1) begin
                drive(w, 0);
                evt_q.push_back('{K_REFUND, w, credit, cyc + 1});
                gnt_q.push_back('{0, cyc + 2});
                step();
                req_mask[w] = 1'b0;
                drive(-1, 0);
                step();
                ptr = (w + 1) % N;
                return;
            end
            code = coins[i];
            u = (code == 1) ? 1 : (code == 2) ? 2 : 0;
            if (u > 0 && credit + u <= CMAX) begin
                credit += u;
                since = 0;
                coin_q.push_back('{code, cyc + 1});
            end else if (credit > 0) begin
                since++;
            end
            drive(w, code);
            step();
        end
        if (end_kind == END_VEND) begin
            drive(w, $urandom_range(0, 3));
            vm_out = 2'(out_code);
            vm_change = 2'(chg);
            evt_q.push_back('{K_VEND, w, chg, cyc + 1});
            gnt_q.push_back('{0, cyc + 2});
            step();
            vm_out = 2'b00;
            vm_change = 2'($urandom);
            req_mask[w] = 1'b0;
            drive(-1, 0);
            step();
        end else begin
            req_mask[w] = 1'b0;
            drive(w, 0);
            if (credit > 0) begin
                evt_q.push_back('{K_REFUND, w, credit, cyc + 1});
                gnt_q.push_back('{0, cyc + 2});
                step();
                drive(-1, 0);
                step();
            end else begin
                gnt_q.push_back('{0, cyc + 1});
                step();
            end
        end
        ptr = (w + 1) % N;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r;
        reset = 1'b0;
        slot_req = '0;
        slot_coin = '0;
        vm_out = 2'b00;
        vm_change = 2'b00;
        #2;
        chk("rst_slot_gnt", 32'(slot_gnt), 32'd0);
        chk("rst_slot_vend", 32'(slot_vend), 32'd0);
        chk("rst_slot_refund", 32'(slot_refund), 32'd0);
        chk("rst_refund_units", 32'(refund_units), 32'd0);
        chk("rst_vm_in", 32'(vm_in), 32'd0);
        chk("rst_vm_rst", 32'(vm_rst), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("vm_rst_before_edge", 32'(vm_rst), 32'd0);
        step();
        chk("vm_rst_after_edge", 32'(vm_rst), 32'd1);
        mon_en = 1'b1;

        // Slot 1 pays 3x5 and vends
        cq.delete(); add(1, 3);
        txn(1, cq, END_VEND, 1, 0);
        // Slot 2 leaves with no credit: no refund
        cq.delete();
        txn(2, cq, END_DROP, 0, 0);
        // Slot 3 pays 10 then stalls: timeout refund of 2
        cq.delete(); add(2, 1); add(0, 16);
        txn(3, cq, END_VEND, 1, 0);
        // Slots 0 and 2 together: 0 first (illegal coin then 5), then 2
        req_mask[2] = 1'b1;
        cq.delete(); add(3, 1); add(1, 1);
        txn(0, cq, END_VEND, 2, 1);
        cq.delete(); add(2, 2);
        txn(2, cq, END_VEND, 1, 3);
        // Vend on the same cycle the timeout would fire
        cq.delete(); add(2, 1); add(0, 15);
        txn(1, cq, END_VEND, 3, 2);
        // Credit overflow: oversized coins dropped, refund 15
        cq.delete(); add(2, 8); add(1, 1); add(1, 1); add(3, 1);
        txn(0, cq, END_DROP, 0, 0);

        repeat (60) begin
            cq.delete();
            n = $urandom_range(0, 10);
            repeat (n) begin
                r = $urandom_range(0, 9);
                add((r < 4) ? 1 : (r < 7) ? 2 : (r < 8) ? 3 : 0, 1);
            end
            if ($urandom_range(0, 3) == 0) add(0, $urandom_range(10, 20));
            if ($urandom_range(0, 2) == 0) req_mask[$urandom_range(0, N - 1)] = 1'b1;
            txn($urandom_range(0, N - 1), cq, $urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(0, 3));
        end
        while (req_mask != '0) begin
            cq.delete(); add(1, 1);
            txn(pick(req_mask, ptr), cq, END_VEND, 1, 0);
        end

        // Reset in the middle of FEED with credit 3
        req_mask[2] = 1'b1;
        gnt_q.push_back('{1 << pick(req_mask, ptr), cyc + 1});
        drive(-1, 0);
        step();
        coin_q.push_back('{1, cyc + 1});
        drive(2, 1);
        step();
        coin_q.push_back('{2, cyc + 1});
        drive(2, 2);
        step();
        drive(2, 0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_slot_gnt", 32'(slot_gnt), 32'd0);
        chk("midrst_slot_refund", 32'(slot_refund), 32'd0);
        chk("midrst_vm_in", 32'(vm_in), 32'd0);
        chk("midrst_vm_rst", 32'(vm_rst), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        req_mask = '0;
        drive(-1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_vm_rst_held", 32'(vm_rst), 32'd0);
        step();
        chk("midrst_vm_rst_release", 32'(vm_rst), 32'd1);
        ptr = 0;
        mon_en = 1'b1;

        // Pointer back at 0: slot 1 wins over slot 3
        req_mask[3] = 1'b1;
        cq.delete(); add(2, 1);
        txn(1, cq, END_VEND, 1, 1);
        cq.delete(); add(1, 2);
        txn(3, cq, END_DROP, 0, 0);
        step();
        step();

        chk("coin_q_drained", 32'(coin_q.size()), 32'd0);
        chk("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
        chk("evt_q_drained", 32'(evt_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
